// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture path.
// CAPTURE_DOWNSAMPLE_EN (see camera_capture) selects 2x2 decimation.
package camera_pkg;

  typedef enum logic [1:0] {
    WAIT_VS_HI,
    WAIT_VS_LO,
    BYTE_HI,
    BYTE_LO
  } cap_state_t;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;

  localparam int R_W    = 4;
  localparam int G_W    = 4;
  localparam int B_W    = 4;
  localparam int PIX_W  = R_W + G_W + B_W;
  localparam int ADDR_W = 17;
  localparam int CNT_W  = 12;

  // b1 = R5G3, b2 = G3B5; keep the top bits of each channel
  function automatic logic [PIX_W-1:0] rgb565_to_444(
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a group of asynchronous inputs.
// Reset clears both stages.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/camera_capture.sv
// Camera byte-stream capture into an RGB444 frame buffer.
// Define CAPTURE_DOWNSAMPLE_EN to store only even columns and lines.
module camera_capture
  import camera_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [PIX_W-1:0]  pix_data,
  output logic              frame_done,
  output logic              overrun
);

`ifdef CAPTURE_DOWNSAMPLE_EN
  localparam logic DS_EN = 1'b1;
`else
  localparam logic DS_EN = 1'b0;
`endif

  localparam int H_EFF = DS_EN ? H_PIXELS / 2 : H_PIXELS;
  localparam int V_EFF = DS_EN ? V_LINES / 2 : V_LINES;

  localparam logic [CNT_W-1:0]  H_LIM  = CNT_W'(H_EFF);
  localparam logic [CNT_W-1:0]  V_LIM  = CNT_W'(V_EFF);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_EFF);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic       pclk_s;
  logic       href_s;
  logic       vsync_s;
  logic [7:0] data_s;

  sync2 #(.W(1)) u_sync_pclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cam_pclk),
    .q    (pclk_s)
  );

  sync2 #(.W(1)) u_sync_href (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cam_href),
    .q    (href_s)
  );

  sync2 #(.W(1)) u_sync_vsync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cam_vsync),
    .q    (vsync_s)
  );

  sync2 #(.W(8)) u_sync_data (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cam_data),
    .q    (data_s)
  );

  cap_state_t state;
  cap_state_t state_nxt;

  logic              pclk_d;
  logic              rise;
  logic              href_d;
  logic [7:0]        b1;
  logic [CNT_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  line_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              frame_wrote;

  logic store_hi;
  logic emit;
  logic fall;
  logic abort;
  logic start;

  assign rise = pclk_s & ~pclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_VS_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store_hi  = 1'b0;
    emit      = 1'b0;
    fall      = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    if (rise) begin
      unique case (state)
        WAIT_VS_HI: begin
          if (vsync_s) state_nxt = WAIT_VS_LO;
        end
        WAIT_VS_LO: begin
          if (!vsync_s) begin
            state_nxt = BYTE_HI;
            start     = 1'b1;
          end
        end
        BYTE_HI: begin
          if (vsync_s) begin
            state_nxt = WAIT_VS_LO;
            abort     = 1'b1;
          end else if (href_s) begin
            state_nxt = BYTE_LO;
            store_hi  = 1'b1;
          end else begin
            fall = href_d;
          end
        end
        BYTE_LO: begin
          if (vsync_s) begin
            state_nxt = WAIT_VS_LO;
            abort     = 1'b1;
          end else if (href_s) begin
            state_nxt = BYTE_HI;
            emit      = 1'b1;
          end else begin
            // odd trailing byte is dropped; phase realigns
            state_nxt = BYTE_HI;
            fall      = href_d;
          end
        end
        default: state_nxt = WAIT_VS_HI;
      endcase
    end
  end

  logic [CNT_W-1:0] col_h;
  logic [CNT_W-1:0] line_h;
  logic             in_range;
  logic             keep;

  assign col_h    = col_cnt >> DS_EN;
  assign line_h   = line_cnt >> DS_EN;
  assign in_range = (col_h < H_LIM) && (line_h < V_LIM);
  assign keep     = !DS_EN || (!col_cnt[0] && !line_cnt[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_d      <= 1'b0;
      href_d      <= 1'b0;
      b1          <= '0;
      col_cnt     <= '0;
      line_cnt    <= '0;
      line_base   <= '0;
      frame_wrote <= 1'b0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pclk_d     <= pclk_s;
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      if (rise) href_d <= href_s;
      if (store_hi) b1 <= data_s;
      if (emit) begin
        if (!in_range) begin
          overrun <= 1'b1;
        end else if (keep) begin
          pix_we      <= 1'b1;
          pix_addr    <= line_base + {{(ADDR_W-CNT_W){1'b0}}, col_h};
          pix_data    <= rgb565_to_444(b1, data_s);
          frame_wrote <= 1'b1;
        end
        if (col_cnt != CNT_MAX) col_cnt <= col_cnt + 1'b1;
      end
      if (fall) begin
        col_cnt <= '0;
        if (col_cnt != '0) begin
          if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
          // decimated rows advance the base only on odd->even
          if (!DS_EN || line_cnt[0]) line_base <= line_base + H_STEP;
        end
      end
      if (start || abort) begin
        col_cnt     <= '0;
        line_cnt    <= '0;
        line_base   <= '0;
        frame_wrote <= 1'b0;
      end
      if (abort) frame_done <= frame_wrote;
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Randomized bench for camera_capture with a queue-based frame model.
// Honours CAPTURE_DOWNSAMPLE_EN when compiled with it.
`timescale 1ns/1ps
module tb_camera_capture;

  localparam int H = 32;
  localparam int V = 8;
`ifdef CAPTURE_DOWNSAMPLE_EN
  localparam int DS = 1;
`else
  localparam int DS = 0;
`endif
  localparam int HE = H >> DS;
  localparam int VE = V >> DS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        pix_we;
  logic [16:0] pix_addr;
  logic [11:0] pix_data;
  logic        frame_done;
  logic        overrun;

  camera_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cam_pclk  (cam_pclk),
    .cam_href  (cam_href),
    .cam_vsync (cam_vsync),
    .cam_data  (cam_data),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #7.5 clk = ~clk;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  row = 0;
  int  frame_wr = 0;
  int  frame_active = 0;
  int  exp_done = 0;
  int  exp_ovr = 0;
  int  n_exp_we = 0;
  int  n_we = 0;
  int  n_done = 0;
  int  last_addr = 0;
  int  first_addr = -1;
  int  arm = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_we) begin
        wr_t e;
        n_we++;
        last_addr = int'(pix_addr);
        if (arm != 0) begin
          first_addr = int'(pix_addr);
          arm = 0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(pix_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pix_addr", 32'(pix_addr), 32'(e.addr));
          check("pix_data", 32'(pix_data), 32'(e.data));
        end
      end
      if (frame_done) n_done++;
    end
  end

  task automatic send_byte(input logic h, input logic v, input logic [7:0] d);
    @(negedge clk);
    cam_href  = h;
    cam_vsync = v;
    cam_data  = d;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    cam_pclk = 1'b1;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    cam_pclk = 1'b0;
  endtask

  task automatic model_pixel(input int col, input logic [7:0] b1,
                             input logic [7:0] b2);
    wr_t w;
    int  r4, g4, b4;
    if ((col >> DS) >= HE || (row >> DS) >= VE) begin
      exp_ovr = 1;
    end else if (DS == 0 || (col % 2 == 0 && row % 2 == 0)) begin
      r4 = int'(b1) >> 4;
      g4 = ((int'(b1) & 7) << 1) | (int'(b2) >> 7);
      b4 = (int'(b2) >> 1) & 15;
      w.addr = 17'((row >> DS) * HE + (col >> DS));
      w.data = 12'((r4 << 8) | (g4 << 4) | b4);
      exp_q.push_back(w);
      frame_wr++;
      n_exp_we++;
    end
  endtask

  task automatic send_line(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      if (i % 2 == 1) model_pixel(i / 2, b[i-1], b[i]);
      send_byte(1'b1, 1'b0, b[i]);
    end
    if (b.size() >= 2) row++;
    send_byte(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    send_byte(1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic rand_line(input int nbytes);
    logic [7:0] b[$];
    for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom_range(0, 255)));
    send_line(b);
  endtask

  task automatic vsync_pulse();
    if (frame_active != 0 && frame_wr > 0) exp_done++;
    for (int i = 0; i < 2; i++) send_byte(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) send_byte(1'b0, 1'b0, 8'h00);
    frame_active = 1;
    frame_wr = 0;
    row = 0;
  endtask

  task automatic settle(input string tag);
    repeat (8) @(negedge clk);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done"}, 32'(n_done), 32'(exp_done));
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    logic [7:0] s1[$];
    int mark;

    repeat (3) @(negedge clk);
    check("rst_we", 32'(pix_we), 32'd0);
    check("rst_addr", 32'(pix_addr), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // four fixed pixels on one line
    vsync_pulse();
    s1 = {8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_line(s1);
    settle("s1");
    check("s1_we", 32'(n_we), 32'(n_exp_we));

    // complete frame
    vsync_pulse();
    settle("s1_end");
    mark = n_we;
    for (int l = 0; l < V; l++) rand_line(2 * H);
    vsync_pulse();
    settle("full");
    check("full_we", 32'(n_we - mark), 32'(HE * VE));
    check("full_last", 32'(last_addr), 32'(HE * VE - 1));
    check("full_ovr0", 32'(overrun), 32'd0);

    // line cut after an odd byte, then a clean line
    rand_line(3);
    rand_line(4);
    rand_line(6);
    settle("odd");

    // over-long line
    vsync_pulse();
    rand_line(2 * H + 4);
    settle("long");
    check("long_ovr", 32'(overrun), 32'd1);

    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      for (int l = 0; l < $urandom_range(1, V + 1); l++)
        rand_line($urandom_range(0, 2 * H + 3));
      settle("rand");
    end
    vsync_pulse();
    rand_line(2 * H);
    vsync_pulse();
    settle("sticky");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // reset in the middle of line 5
    for (int l = 0; l < 5; l++) rand_line(2 * H);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      if (i % 2 == 1) model_pixel(i / 2, cam_data, d);
      send_byte(1'b1, 1'b0, d);
    end
    repeat (8) @(negedge clk);
    check("pre_rst_drained", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    check("mid_rst_we", 32'(pix_we), 32'd0);
    rst_n = 1'b1;
    exp_ovr = 0;
    frame_active = 0;
    frame_wr = 0;
    row = 0;
    mark = n_we;
    for (int i = 0; i < 8; i++) send_byte(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    send_byte(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) send_byte(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) send_byte(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    repeat (8) @(negedge clk);
    check("no_we_before_vs", 32'(n_we - mark), 32'd0);
    arm = 1;
    vsync_pulse();
    rand_line(2 * H);
    rand_line(2 * H);
    vsync_pulse();
    settle("post_rst");
    check("post_rst_first", 32'(first_addr), 32'd0);
    check("total_we", 32'(n_we), 32'(n_exp_we));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
